// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the request, memory and status signals of the shared memory port
// arbiter.
//   master : arbiter view. It receives the IF/DM requests and the memory
//            response, and drives the memory strobe, the mux select, the
//            done pulses, the read-data registers, the stalls and the
//            watchdog flag.
//   slave  : environment view (pipeline stages plus memory).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        if_req;
  logic        dm_req;
  logic        dm_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_sel;
  logic        mem_req;
  logic        mem_we;
  logic        if_done;
  logic        dm_done;
  logic [31:0] if_rdata;
  logic [31:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic        timeout_err;

  modport master (
    input  if_req, dm_req, dm_we, mem_ack, mem_rdata,
    output mem_sel, mem_req, mem_we, if_done, dm_done,
           if_rdata, dm_rdata, if_stall, dm_stall, timeout_err
  );

  modport slave (
    output if_req, dm_req, dm_we, mem_ack, mem_rdata,
    input  mem_sel, mem_req, mem_we, if_done, dm_done,
           if_rdata, dm_rdata, if_stall, dm_stall, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between the instruction-fetch (IF) and data-memory
// (DM) stages. The arbiter grants one port at a time, with round-robin on a
// tie. It drives the select of the 2:1 address/data mux and sequences the
// request/acknowledge handshake. It latches read data for each port and
// stalls any stage whose access has not completed. A watchdog aborts a
// transaction that never receives an acknowledge.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mem_port_arbiter_if.master
//            if_req/dm_req   level requests, held until the matching done
//            dm_we           DM write enable, sampled at grant
//            mem_ack         one-cycle completion pulse from memory
//            mem_rdata       read data, valid with mem_ack
//            mem_sel         mux select (0 = IF, 1 = DM)
//            mem_req/mem_we  memory strobe and write enable
//            if_done/dm_done one-cycle completion pulses
//            if_rdata/dm_rdata read data holding registers
//            if_stall/dm_stall req & ~done (combinational)
//            timeout_err     sticky watchdog flag
//
// Parameters:
//   TIMEOUT : maximum number of BUSY cycles without mem_ack (0 = no watchdog)
//   CNT_W   : width of the watchdog counter; must be able to hold TIMEOUT
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit             WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        last_gnt_reg, last_gnt_next;   // 0 = IF, 1 = DM
  logic        mem_sel_reg, mem_sel_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic        if_done_reg, if_done_next;
  logic        dm_done_reg, dm_done_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] dm_rdata_reg, dm_rdata_next;
  logic        timeout_err_reg, timeout_err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic if_elig;
  logic dm_elig;
  logic grant_dm;

  // A port is not eligible on its own done cycle. This prevents a re-grant
  // before the requester has had a chance to drop its level request.
  assign if_elig = bus.if_req & ~if_done_reg;
  assign dm_elig = bus.dm_req & ~dm_done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      last_gnt_reg    <= 1'b0;
      mem_sel_reg     <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      if_done_reg     <= 1'b0;
      dm_done_reg     <= 1'b0;
      if_rdata_reg    <= '0;
      dm_rdata_reg    <= '0;
      timeout_err_reg <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      last_gnt_reg    <= last_gnt_next;
      mem_sel_reg     <= mem_sel_next;
      mem_req_reg     <= mem_req_next;
      mem_we_reg      <= mem_we_next;
      if_done_reg     <= if_done_next;
      dm_done_reg     <= dm_done_next;
      if_rdata_reg    <= if_rdata_next;
      dm_rdata_reg    <= dm_rdata_next;
      timeout_err_reg <= timeout_err_next;
      cnt_reg         <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_gnt_next    = last_gnt_reg;
    mem_sel_next     = mem_sel_reg;
    mem_req_next     = mem_req_reg;
    mem_we_next      = mem_we_reg;
    if_done_next     = 1'b0;
    dm_done_next     = 1'b0;
    if_rdata_next    = if_rdata_reg;
    dm_rdata_next    = dm_rdata_reg;
    timeout_err_next = timeout_err_reg;
    cnt_next         = cnt_reg;
    // On a tie, DM wins when IF was granted last, which gives round-robin.
    grant_dm         = dm_elig & (~if_elig | ~last_gnt_reg);

    case (state_reg)
      IDLE: begin
        if (if_elig | dm_elig) begin
          state_next    = BUSY;
          mem_req_next  = 1'b1;
          mem_sel_next  = grant_dm;
          mem_we_next   = grant_dm & bus.dm_we;
          last_gnt_next = grant_dm;
          cnt_next      = '0;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          // An acknowledge takes priority over a watchdog expiry on the same edge.
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (mem_sel_reg) begin
            dm_done_next  = 1'b1;
            dm_rdata_next = bus.mem_rdata;
          end else begin
            if_done_next  = 1'b1;
            if_rdata_next = bus.mem_rdata;
          end
        end else if (WDOG_EN && (cnt_reg == CNT_LAST)) begin
          // Abort: release the requester, but leave its read data untouched.
          state_next       = IDLE;
          mem_req_next     = 1'b0;
          mem_we_next      = 1'b0;
          timeout_err_next = 1'b1;
          if (mem_sel_reg) dm_done_next = 1'b1;
          else             if_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_sel     = mem_sel_reg;
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_we      = mem_we_reg;
  assign bus.if_done     = if_done_reg;
  assign bus.dm_done     = dm_done_reg;
  assign bus.if_rdata    = if_rdata_reg;
  assign bus.dm_rdata    = dm_rdata_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.if_stall    = bus.if_req & ~if_done_reg;
  assign bus.dm_stall    = bus.dm_req & ~dm_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (TIMEOUT=4). A transaction-level
// model tracks the last grant, the per-port read data and the sticky
// timeout flag. The expected outcome of each access follows from the arbiter
// rules: the winner of a tie is the port opposite the last grant, and the
// busy length is min(ack delay, TIMEOUT).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_last;     // 0 = IF granted last, 1 = DM
  bit          m_terr;
  logic [31:0] m_if_rd;
  logic [31:0] m_dm_rd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last  = 1'b0;
    m_terr  = 1'b0;
    m_if_rd = '0;
    m_dm_rd = '0;
  endtask

  // Serve one access. The caller has already driven the requests. Drops the
  // served request in its done cycle and returns in that cycle.
  task automatic do_txn(input int delay, input logic [31:0] data,
                        input bit exp_dm, input bit exp_we);
    int w;
    int n;
    bit got_ack;
    w = 0;
    while (bus.mem_req !== 1'b1 && w < 8) begin
      step();
      w++;
    end
    n_checks++;
    if (bus.mem_req !== 1'b1 || w != 1) begin
      n_fail++;
      $display("FAIL grant_latency: mem_req=%b after %0d cycles, required 1 after 1 cycle", bus.mem_req, w);
      return;
    end
    n = (delay <= TO) ? delay : TO;
    for (int i = 1; i <= n; i++) begin
      n_checks++;
      if ({bus.mem_req, bus.mem_sel, bus.mem_we, bus.if_done, bus.dm_done} !==
          {1'b1, exp_dm, exp_we, 2'b00}) begin
        n_fail++;
        $display("FAIL busy_cycle%0d: req/sel/we/ifd/dmd=%b required %b", i,
                 {bus.mem_req, bus.mem_sel, bus.mem_we, bus.if_done, bus.dm_done},
                 {1'b1, exp_dm, exp_we, 2'b00});
      end
      n_checks++;
      if ({bus.if_stall, bus.dm_stall} !== {bus.if_req, bus.dm_req}) begin
        n_fail++;
        $display("FAIL busy_stall: if/dm_stall=%b required %b",
                 {bus.if_stall, bus.dm_stall}, {bus.if_req, bus.dm_req});
      end
      if (i == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
      end else begin
        bus.mem_rdata = $urandom;
      end
      step();
      bus.mem_ack = 1'b0;
    end
    got_ack = (delay <= TO);
    if (got_ack) begin
      if (exp_dm) m_dm_rd = data;
      else        m_if_rd = data;
    end else begin
      m_terr = 1'b1;
    end
    m_last = exp_dm;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_sel, bus.if_done, bus.dm_done} !==
        {1'b0, 1'b0, exp_dm, ~exp_dm, exp_dm}) begin
      n_fail++;
      $display("FAIL done_cycle: req/we/sel/ifd/dmd=%b required %b",
               {bus.mem_req, bus.mem_we, bus.mem_sel, bus.if_done, bus.dm_done},
               {1'b0, 1'b0, exp_dm, ~exp_dm, exp_dm});
    end
    n_checks++;
    if ({bus.if_rdata, bus.dm_rdata} !== {m_if_rd, m_dm_rd}) begin
      n_fail++;
      $display("FAIL rdata: if=%h dm=%h required if=%h dm=%h",
               bus.if_rdata, bus.dm_rdata, m_if_rd, m_dm_rd);
    end
    n_checks++;
    if (bus.timeout_err !== m_terr) begin
      n_fail++;
      $display("FAIL timeout_err: %b required %b", bus.timeout_err, m_terr);
    end
    n_checks++;
    if ((exp_dm ? bus.dm_stall : bus.if_stall) !== 1'b0) begin
      n_fail++;
      $display("FAIL done_stall: stall=%b required 0", exp_dm ? bus.dm_stall : bus.if_stall);
    end
    $display("txn port=%s we=%0d delay=%0d data=%h timeout=%0d", exp_dm ? "DM" : "IF",
             exp_we, delay, data, !got_ack);
    if (exp_dm) bus.dm_req = 1'b0;
    else        bus.if_req = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if ({bus.mem_req, bus.if_done, bus.dm_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s: req/ifd/dmd=%b required 000", tag,
               {bus.mem_req, bus.if_done, bus.dm_done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 0; bus.dm_req = 0; bus.dm_we = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
    repeat (2) step();
    n_checks++;
    if ({bus.mem_sel, bus.mem_req, bus.mem_we, bus.if_done, bus.dm_done, bus.timeout_err,
         bus.if_rdata, bus.dm_rdata} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_state: outputs not all zero (sel=%b req=%b we=%b if_rd=%h dm_rd=%h terr=%b)",
               bus.mem_sel, bus.mem_req, bus.mem_we, bus.if_rdata, bus.dm_rdata, bus.timeout_err);
    end
    rst = 1'b0;
    model_reset();
    step();
    check_idle("reset_idle");
    $display("txn reset");
  endtask

  task automatic test_lone_if();
    bus.if_req = 1'b1;
    do_txn(3, 32'h2402000A, 1'b0, 1'b0);
    step();
    check_idle("lone_if_after");
  endtask

  task automatic test_tie();
    bus.dm_we = 1'b1;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    do_txn(2, 32'hDEAD0001, 1'b1, 1'b1);
    do_txn(1, 32'h0BAD0002, 1'b0, 1'b0);
    step();
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    do_txn(1, 32'h12345678, 1'b1, 1'b1);
    do_txn(2, 32'h9ABCDEF0, 1'b0, 1'b0);
    step();
    check_idle("tie_after");
    bus.dm_we = 1'b0;
  endtask

  task automatic test_no_regrant();
    bus.dm_we = 1'b0;
    bus.dm_req = 1'b1;
    step();
    n_checks++;
    if ({bus.mem_req, bus.mem_sel} !== 2'b11) begin
      n_fail++;
      $display("FAIL noregrant_grant: req/sel=%b required 11", {bus.mem_req, bus.mem_sel});
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    step();
    bus.mem_ack = 1'b0;
    m_dm_rd = 32'hCAFEF00D; m_last = 1'b1;
    n_checks++;
    if (bus.dm_done !== 1'b1) begin
      n_fail++;
      $display("FAIL noregrant_done: dm_done=%b required 1", bus.dm_done);
    end
    step();   // request still held through the done cycle
    n_checks++;
    if ({bus.mem_req, bus.dm_done, bus.dm_stall} !== 3'b001) begin
      n_fail++;
      $display("FAIL noregrant_k1: req/dmd/dm_stall=%b required 001",
               {bus.mem_req, bus.dm_done, bus.dm_stall});
    end
    bus.dm_req = 1'b0;
    // an acknowledge while idle must be ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    step();
    bus.mem_ack = 1'b0;
    check_idle("noregrant_k2");
    n_checks++;
    if (bus.dm_rdata !== m_dm_rd) begin
      n_fail++;
      $display("FAIL idle_ack_rdata: dm_rdata=%h required %h", bus.dm_rdata, m_dm_rd);
    end
    step();
    check_idle("noregrant_k3");
    $display("txn no_regrant");
  endtask

  task automatic test_ack_on_last();
    bus.dm_req = 1'b1;
    do_txn(TO, 32'hA5A5F00F, 1'b1, 1'b0);
    step();
    check_idle("ack_last_after");
  endtask

  task automatic test_timeout();
    bus.dm_req = 1'b1;
    do_txn(99, 32'hFFFFFFFF, 1'b1, 1'b0);
    step();
    check_idle("timeout_after");
    n_checks++;
    if (bus.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: timeout_err=%b required 1", bus.timeout_err);
    end
    bus.if_req = 1'b1;
    do_txn(2, 32'h00C0FFEE, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_random();
    int pat;
    bit we;
    bit first;
    for (int t = 0; t < 40; t++) begin
      pat = $urandom_range(0, 2);
      we  = 1'($urandom_range(0, 1));
      bus.dm_we  = we;
      bus.if_req = (pat != 1);
      bus.dm_req = (pat != 0);
      if (pat == 2) begin
        first = ~m_last;
        do_txn($urandom_range(1, 6), $urandom, first, first & we);
        do_txn($urandom_range(1, 6), $urandom, ~first, ~first & we);
      end else begin
        do_txn($urandom_range(1, 6), $urandom, pat == 1, (pat == 1) & we);
      end
      step();
      check_idle("random_gap");
    end
  endtask

  task automatic test_reset_busy();
    bus.dm_we = 1'b1;
    bus.dm_req = 1'b1;
    step();
    n_checks++;
    if ({bus.mem_req, bus.mem_sel, bus.mem_we} !== 3'b111) begin
      n_fail++;
      $display("FAIL rstbusy_grant: req/sel/we=%b required 111", {bus.mem_req, bus.mem_sel, bus.mem_we});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_sel, bus.mem_req, bus.mem_we, bus.if_done, bus.dm_done, bus.timeout_err,
         bus.if_rdata, bus.dm_rdata} !== 70'd0) begin
      n_fail++;
      $display("FAIL rstbusy_async: sel=%b req=%b we=%b dmd=%b terr=%b if_rd=%h dm_rd=%h required all 0",
               bus.mem_sel, bus.mem_req, bus.mem_we, bus.dm_done, bus.timeout_err,
               bus.if_rdata, bus.dm_rdata);
    end
    bus.dm_req = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rstbusy_nodone");
    end
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    do_txn(1, 32'h0F0F0F0F, 1'b1, 1'b1);
    do_txn(3, 32'hF0F0F0F0, 1'b0, 1'b0);
    step();
    check_idle("rstbusy_after");
  endtask

  initial begin
    test_reset();
    test_lone_if();
    test_tie();
    test_no_regrant();
    test_ack_on_last();
    test_timeout();
    test_random();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single memory port shared by the instruction-fetch (IF) and data-memory (DM) stages of the pipeline.
- Drives the select line of the 32-bit 2:1 address/data mux in front of memory, and sequences each request/acknowledge transaction.
- Latches read data per port and stalls the losing or waiting stage.
- Includes a watchdog that aborts any transaction that never receives an acknowledge.

Parameters:
TIMEOUT, 64, max cycles in BUSY without mem_ack before abort; 0 disables the watchdog
CNT_W, 7, watchdog counter width; must hold TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
if_req  input  1  IF access request; level, held until if_done
dm_req  input  1  DM access request; level, held until dm_done
dm_we  input  1  DM write enable; sampled at grant
mem_ack  input  1  memory completion; one-cycle pulse
mem_rdata  input  32  memory read data; valid while mem_ack=1
mem_sel  output  1  select of the shared 2:1 mux; 0=IF, 1=DM
mem_req  output  1  memory access strobe
mem_we  output  1  memory write enable
if_done  output  1  one-cycle IF completion pulse
dm_done  output  1  one-cycle DM completion pulse
if_rdata  output  32  IF read data holding register
dm_rdata  output  32  DM read data holding register
if_stall  output  1  if_req & ~if_done (combinational)
dm_stall  output  1  dm_req & ~dm_done (combinational)
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: IDLE; last_gnt=IF.
- Reset output values: mem_sel, mem_req, mem_we, if_done, dm_done and timeout_err are 0; if_rdata and dm_rdata are 0; watchdog count is 0.
- Reset during BUSY aborts the transaction immediately and emits no done pulse.
- State machine: IDLE, BUSY. All outputs except the stalls are registered.
- IDLE, eligible requests: if_req with if_done=0; dm_req with dm_done=0. Masking on the done cycle prevents a re-grant before the requester drops req.
- IDLE, one eligible request: grant it.
- IDLE, both eligible: grant the port opposite last_gnt (round-robin). After reset, DM wins the first tie.
- Grant at edge t:
  - state=BUSY
  - mem_req=1
  - mem_sel = 1 for DM, 0 for IF
  - mem_we = dm_we for DM, 0 for IF
  - last_gnt = granted port
  - watchdog count = 0
  - mem_sel and mem_we stay stable for the whole of BUSY.
- BUSY with mem_ack=1 at edge k:
  - state=IDLE
  - mem_req=0, mem_we=0
  - granted port's done=1 for exactly one cycle
  - granted port's rdata register loads mem_rdata, including on writes
  - mem_sel holds its value.
- Latency: request seen in IDLE at cycle 0 gives mem_req=1 in cycle 1. mem_ack in cycle k gives done in cycle k+1. Minimum turnaround is 3 cycles with an ack in cycle 1. The next grant comes no earlier than cycle k+2.
- Watchdog, BUSY without mem_ack: count increments each cycle. On reaching TIMEOUT-1 (TIMEOUT≠0), at the next edge:
  - state=IDLE, mem_req=0
  - granted port's done=1
  - its rdata register is unchanged
  - timeout_err=1, held until rst.
- mem_ack and timeout on the same edge: mem_ack wins; timeout_err is not set.
- mem_ack in IDLE is ignored.
- Requester dropping req during BUSY: the transaction still completes and done is still pulsed.
- A requester that did not win sees stall=1 until its own done.

Test Plan:
1. rst pulsed mid-cycle while BUSY with mem_sel=1 -> all outputs 0 asynchronously; no dm_done follows; the first later tie grants DM.
2. Lone if_req; mem_ack in cycle 3 with mem_rdata=0x2402000A -> mem_req=1 in cycles 1-3; if_done=1 in cycle 4; if_rdata=0x2402000A; mem_sel=0 throughout; mem_we=0.
3. if_req and dm_req (dm_we=1) raised together, both held -> DM served first (mem_sel=1, mem_we=1), then IF (mem_sel=0, mem_we=0). A third tie grants DM again; if_stall=1 during the DM transaction.
4. dm_req held through dm_done in cycle k -> no re-grant in cycle k+1; with the request dropped in k+1, mem_req stays 0.
5. TIMEOUT=4, lone dm_req, no mem_ack -> mem_req high 4 cycles; dm_done pulses; timeout_err=1 and stays set; dm_rdata unchanged.
6. TIMEOUT=4, mem_ack on the final watchdog cycle -> normal completion; timeout_err stays 0.
